core_control_fsm: RTL and testbench

Multi-cycle sequencer for the RV32I core. It owns the program counter and steps each instruction through fetch, decode, execute, memory and writeback. It uses the `instr_kind_t` classification from the decoder to pick the path through those stages. It drives the instruction-memory and data-memory request handshakes, the register-file write enable and the retire/trap status.

---
 rtl/core_control_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_core_control_fsm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_control_fsm.sv
// Multi-cycle RV32I control sequencer: owns the PC and walks each instruction
// through fetch, decode, execute, memory and writeback, halting on traps.
package core_control_pkg;
    typedef enum logic [4:0] {
        IK_LUI, IK_AUIPC, IK_JAL, IK_JALR,
        IK_BEQ, IK_BNE, IK_BLT, IK_BGE, IK_BLTU, IK_BGEU,
        IK_LB, IK_LH, IK_LW, IK_LBU, IK_LHU,
        IK_SB, IK_SH, IK_SW,
        IK_ALU_IMM, IK_ALU_REG,
        IK_FENCE, IK_FENCE_I,
        IK_ECALL, IK_EBREAK,
        IK_CSR
    } instr_kind_t;
endpackage

module core_control_fsm
    import core_control_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned DECODE_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic        ir_load,
    input  instr_kind_t instr_kind,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        retire,
    output logic [31:0] instret,
    output logic        halted,
    output logic [1:0]  trap_cause
);

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK, ST_HALT
    } state_t;

    localparam logic [3:0] DEC_LAT = 4'(DECODE_LATENCY);

    state_t      state_r, state_s;
    logic [31:0] pc_r, npc_r, npc_s, pc_plus4_s, instret_r;
    logic [3:0]  dcnt_r;
    logic        is_store_r, store_s;
    logic        imem_req_r, dmem_req_r, dmem_we_r, rf_we_r, halted_r;
    logic [1:0]  trap_cause_r, trap_s;
    logic        commit_s, fetch_done_s;

    function automatic logic is_store_f(input instr_kind_t k);
        logic r;
        case (k)
            IK_SB, IK_SH, IK_SW: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    assign pc_plus4_s = pc_r + 32'd4;
    assign store_s    = (state_r == ST_EXECUTE) ? is_store_f(instr_kind) : is_store_r;

    // Next-state, next-PC, commit and trap decisions.
    always_comb begin
        state_s      = state_r;
        npc_s        = npc_r;
        commit_s     = 1'b0;
        trap_s       = 2'd0;
        fetch_done_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (imem_req_r && imem_ready) begin
                    fetch_done_s = 1'b1;
                    state_s      = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dcnt_r <= 4'd1) begin
                    state_s = ST_EXECUTE;
                end else begin
                    state_s = ST_DECODE;
                end
            end
            ST_EXECUTE: begin
                npc_s   = pc_plus4_s;
                state_s = ST_FETCH;
                case (instr_kind)
                    IK_BEQ, IK_BNE, IK_BLT, IK_BGE, IK_BLTU, IK_BGEU: begin
                        if (branch_taken) begin
                            npc_s = branch_target;
                        end else begin
                            npc_s = pc_plus4_s;
                        end
                    end
                    IK_JAL, IK_JALR: begin
                        npc_s   = branch_target;
                        state_s = ST_WRITEBACK;
                    end
                    IK_LB, IK_LH, IK_LW, IK_LBU, IK_LHU,
                    IK_SB, IK_SH, IK_SW: state_s = ST_MEM;
                    IK_ECALL: begin
                        npc_s   = pc_r;
                        state_s = ST_HALT;
                        trap_s  = 2'd1;
                    end
                    IK_EBREAK: begin
                        npc_s   = pc_r;
                        state_s = ST_HALT;
                        trap_s  = 2'd2;
                    end
                    IK_LUI, IK_AUIPC, IK_ALU_IMM, IK_ALU_REG,
                    IK_CSR: state_s = ST_WRITEBACK;
                    IK_FENCE, IK_FENCE_I: state_s = ST_FETCH;
                    default: state_s = ST_FETCH;
                endcase
                // Only paths that commit in this very cycle are alignment-checked here.
                if (state_s == ST_FETCH) begin
                    if (npc_s[1:0] != 2'd0) begin
                        state_s = ST_HALT;
                        trap_s  = 2'd3;
                    end else begin
                        commit_s = 1'b1;
                    end
                end else begin
                    commit_s = 1'b0;
                end
            end
            ST_MEM: begin
                if (dmem_req_r && dmem_ready) begin
                    if (!is_store_r) begin
                        state_s = ST_WRITEBACK;
                    end else if (npc_r[1:0] != 2'd0) begin
                        state_s = ST_HALT;
                        trap_s  = 2'd3;
                    end else begin
                        commit_s = 1'b1;
                        state_s  = ST_FETCH;
                    end
                end else begin
                    state_s = ST_MEM;
                end
            end
            ST_WRITEBACK: begin
                if (npc_r[1:0] != 2'd0) begin
                    state_s = ST_HALT;
                    trap_s  = 2'd3;
                end else begin
                    commit_s = 1'b1;
                    state_s  = ST_FETCH;
                end
            end
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_FETCH;
        endcase
    end

    // State, architectural registers and registered request/enable outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_FETCH;
            pc_r         <= RESET_PC;
            npc_r        <= RESET_PC;
            instret_r    <= 32'd0;
            dcnt_r       <= 4'd0;
            is_store_r   <= 1'b0;
            imem_req_r   <= 1'b0;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            rf_we_r      <= 1'b0;
            halted_r     <= 1'b0;
            trap_cause_r <= 2'd0;
        end else begin
            state_r    <= state_s;
            npc_r      <= npc_s;
            is_store_r <= store_s;
            if (commit_s) begin
                pc_r      <= npc_s;
                instret_r <= instret_r + 32'd1;
            end
            if (fetch_done_s) begin
                dcnt_r <= DEC_LAT;
            end else if (state_r == ST_DECODE) begin
                dcnt_r <= dcnt_r - 4'd1;
            end
            imem_req_r <= (state_s == ST_FETCH);
            dmem_req_r <= (state_s == ST_MEM);
            dmem_we_r  <= (state_s == ST_MEM) && store_s;
            // A misaligned link target must not write the register file.
            rf_we_r    <= (state_s == ST_WRITEBACK) && (npc_s[1:0] == 2'd0);
            halted_r   <= (state_s == ST_HALT);
            if ((state_r != ST_HALT) && (state_s == ST_HALT)) begin
                trap_cause_r <= trap_s;
            end
        end
    end

    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign ir_load    = fetch_done_s && !rst;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign rf_we      = rf_we_r;
    assign pc         = pc_r;
    assign retire     = commit_s && !rst;
    assign instret    = instret_r;
    assign halted     = halted_r;
    assign trap_cause = trap_cause_r;

endmodule

// File: tb/tb_core_control_fsm.sv
// Directed bench for core_control_fsm: each step sets inputs at the falling edge
// and checks outputs 1 ns later against hand-computed values.
module tb_core_control_fsm;
    import core_control_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        ir_load;
    instr_kind_t instr_kind = IK_ALU_IMM;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready = 1'b0;
    logic        rf_we;
    logic [31:0] pc;
    logic        retire;
    logic [31:0] instret;
    logic        halted;
    logic [1:0]  trap_cause;

    int checks = 0;
    int errors = 0;

    core_control_fsm dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .ir_load(ir_load), .instr_kind(instr_kind),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .rf_we(rf_we), .pc(pc), .retire(retire), .instret(instret),
        .halted(halted), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    // Fetch (ready at once) and two decode cycles; returns in the EXECUTE cycle.
    task automatic start_instr(input instr_kind_t k, input logic tk, input logic [31:0] tgt);
        imem_ready    = 1'b1;
        instr_kind    = k;
        branch_taken  = tk;
        branch_target = tgt;
        #1;
        chk("ir_load", {31'd0, ir_load}, 32'd1);
        cyc();
        imem_ready = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        cyc();
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_trap", {30'd0, trap_cause}, 32'd0);
        chk("rst_outs", {26'd0, ir_load, dmem_req, dmem_we, rf_we, retire, imem_req}, 32'd0);
        rst = 1'b0;
        cyc();
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, 32'd0);

        // ADDI: rf_we/retire in the fifth cycle
        start_instr(IK_ALU_IMM, 1'b0, 32'd0);
        chk("alu_exec_retire", {31'd0, retire}, 32'd0);
        cyc();
        chk("alu_wb_rf_we", {31'd0, rf_we}, 32'd1);
        chk("alu_wb_retire", {31'd0, retire}, 32'd1);
        cyc();
        chk("alu_pc", pc, 32'd4);
        chk("alu_instret", instret, 32'd1);
        chk("alu_refetch", {31'd0, imem_req}, 32'd1);

        // Taken and not-taken BEQ
        start_instr(IK_BEQ, 1'b1, 32'h100);
        chk("beq_t_retire", {31'd0, retire}, 32'd1);
        chk("beq_t_rf_we", {31'd0, rf_we}, 32'd0);
        cyc();
        chk("beq_t_addr", imem_addr, 32'h100);
        chk("beq_t_instret", instret, 32'd2);
        start_instr(IK_BEQ, 1'b0, 32'h200);
        chk("beq_nt_retire", {31'd0, retire}, 32'd1);
        cyc();
        chk("beq_nt_addr", imem_addr, 32'h104);

        // LW with dmem_ready three cycles late
        start_instr(IK_LW, 1'b0, 32'd0);
        chk("lw_exec_retire", {31'd0, retire}, 32'd0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("lw_wait_req", {31'd0, dmem_req}, 32'd1);
            chk("lw_wait_we", {31'd0, dmem_we}, 32'd0);
            cyc();
        end
        dmem_ready = 1'b1;
        #1;
        chk("lw_rdy_req", {31'd0, dmem_req}, 32'd1);
        chk("lw_rdy_we", {31'd0, dmem_we}, 32'd0);
        chk("lw_rdy_retire", {31'd0, retire}, 32'd0);
        cyc();
        dmem_ready = 1'b0;
        #1;
        chk("lw_wb_rf_we", {31'd0, rf_we}, 32'd1);
        chk("lw_wb_retire", {31'd0, retire}, 32'd1);
        chk("lw_wb_dmem_req", {31'd0, dmem_req}, 32'd0);
        cyc();
        chk("lw_pc", pc, 32'h108);
        chk("lw_instret", instret, 32'd4);

        // SW with immediate ready
        start_instr(IK_SW, 1'b0, 32'd0);
        cyc();
        dmem_ready = 1'b1;
        #1;
        chk("sw_we", {31'd0, dmem_we}, 32'd1);
        chk("sw_retire", {31'd0, retire}, 32'd1);
        chk("sw_rf_we", {31'd0, rf_we}, 32'd0);
        cyc();
        dmem_ready = 1'b0;
        #1;
        chk("sw_pc", pc, 32'h10C);
        chk("sw_instret", instret, 32'd5);
        chk("sw_req_drop", {31'd0, dmem_req}, 32'd0);

        // Unrecognised kind: pc+4, retire, no writeback
        start_instr(instr_kind_t'(5'd30), 1'b0, 32'd0);
        chk("unk_retire", {31'd0, retire}, 32'd1);
        chk("unk_rf_we", {31'd0, rf_we}, 32'd0);
        cyc();
        chk("unk_pc", pc, 32'h110);

        // JAL to the top word, then ADDI wraps the PC
        start_instr(IK_JAL, 1'b0, 32'hFFFF_FFFC);
        cyc();
        chk("jal_rf_we", {31'd0, rf_we}, 32'd1);
        cyc();
        chk("jal_pc", pc, 32'hFFFF_FFFC);
        start_instr(IK_ALU_IMM, 1'b0, 32'd0);
        cyc();
        cyc();
        chk("pc_wrap", pc, 32'd0);
        chk("pc_wrap_instret", instret, 32'd8);

        // instret wraps to zero
        force dut.instret_r = 32'hFFFF_FFFF;
        #1;
        release dut.instret_r;
        #1;
        chk("instret_preload", instret, 32'hFFFF_FFFF);
        start_instr(IK_BNE, 1'b0, 32'd0);
        cyc();
        chk("instret_wrap", instret, 32'd0);
        chk("instret_wrap_pc", pc, 32'd4);

        // ECALL halts without retiring; fetch ready is ignored afterwards
        start_instr(IK_ECALL, 1'b0, 32'd0);
        chk("ecall_retire", {31'd0, retire}, 32'd0);
        cyc();
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ecall_halted", {31'd0, halted}, 32'd1);
            chk("ecall_cause", {30'd0, trap_cause}, 32'd1);
            chk("ecall_quiet", {30'd0, imem_req, ir_load}, 32'd0);
            chk("ecall_pc", pc, 32'd4);
            chk("ecall_instret", instret, 32'd0);
            cyc();
        end

        // Reset leaves HALT; JAL to a misaligned target traps
        do_reset();
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_cause", {30'd0, trap_cause}, 32'd0);
        chk("rst2_req", {31'd0, imem_req}, 32'd1);
        start_instr(IK_JAL, 1'b0, 32'h102);
        cyc();
        chk("mis_rf_we", {31'd0, rf_we}, 32'd0);
        chk("mis_retire", {31'd0, retire}, 32'd0);
        cyc();
        chk("mis_cause", {30'd0, trap_cause}, 32'd3);
        chk("mis_halted", {31'd0, halted}, 32'd1);
        chk("mis_pc", pc, 32'd0);
        chk("mis_instret", instret, 32'd0);

        // EBREAK
        do_reset();
        start_instr(IK_EBREAK, 1'b0, 32'd0);
        cyc();
        chk("ebreak_cause", {30'd0, trap_cause}, 32'd2);

        // Reset during a MEM wait; coincident dmem_ready is ignored
        do_reset();
        start_instr(IK_ALU_IMM, 1'b0, 32'd0);
        cyc();
        cyc();
        start_instr(IK_LW, 1'b0, 32'd0);
        cyc();
        chk("mrst_req_before", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk("mrst_retire", {31'd0, retire}, 32'd0);
        cyc();
        chk("mrst_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("mrst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("mrst_pc", pc, 32'd0);
        chk("mrst_instret", instret, 32'd0);
        rst = 1'b0;
        dmem_ready = 1'b0;
        cyc();
        chk("mrst_refetch", {31'd0, imem_req}, 32'd1);
        chk("mrst_addr", imem_addr, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
